// File: rtl/sram1rw_ctrl_pkg.sv
// Shared defaults, word/address types and controller state encoding for the
// single-port SRAM request controller.
package sram1rw_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 17;
    localparam int DEF_DEPTH  = 1024;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/sram1rw_rsp_fifo.sv
// Two-entry read-response queue; head is presented combinationally and stays
// put until popped.
module sram1rw_rsp_fifo #(
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    // A push while full is only taken if the head leaves in the same cycle.
    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ((count_q != 2'd2) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign valid = (count_q != 2'd0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sram1rw_req_ctrl.sv
// Valid/ready front end for a 1RW synchronous SRAM with in-order read responses.
// Optional SRAM1RW_CTRL_ZERO_FILL_EN clears the whole array after reset.
module sram1rw_req_ctrl
    import sram1rw_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    input  logic [DATA_W-1:0] sram_o,
    output logic              busy
);

    logic       rd_pending_q, rd_pending_d;
    logic       fire, pop, fill_active;
    logic [1:0] count;
    logic [2:0] occupancy;

`ifdef SRAM1RW_CTRL_ZERO_FILL_EN
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            ST_FILL: begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == FILL_LAST) begin
                    state_d    = ST_IDLE;
                    fill_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Reset parks the FSM at the start of the fill so it restarts from 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign fill_active = (state_q == ST_FILL);
`else
    assign fill_active = 1'b0;
`endif

    assign busy = ~reset_n | fill_active;

    // Slots already promised: queued responses plus a read landing this cycle.
    assign pop       = rsp_valid & rsp_ready;
    assign occupancy = {1'b0, count} + {2'b00, rd_pending_q} - {2'b00, pop};
    assign req_ready = ~busy & (occupancy < 3'd2);
    assign fire      = req_valid & req_ready;

    assign rd_pending_d = fire & ~req_write;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
        end
    end

    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_oeb = 1'b1;
        sram_a   = req_addr;
        sram_i   = req_wdata;
`ifdef SRAM1RW_CTRL_ZERO_FILL_EN
        if (reset_n && fill_active) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = fill_cnt_q;
            sram_i   = '0;
        end else
`endif
        if (fire) begin
            sram_csb = 1'b0;
            sram_web = ~req_write;
            sram_oeb = req_write;
        end
    end

    sram1rw_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk       (clock),
        .reset_n   (reset_n),
        .push      (rd_pending_q),
        .push_data (sram_o),
        .pop       (pop),
        .valid     (rsp_valid),
        .head      (rsp_rdata),
        .count     (count)
    );

endmodule

// File: doc/sram1rw_req_ctrl.md
SRAM1RW_REQ_CTRL -- requirements
Module: sram1rw_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 17, SRAM word width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of SRAM words (2**ADDR_W).
REQ-004 SHALL have port clock  input  1  sole clock; also tied externally to the SRAM CE pin.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_valid  input  1  request offered.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_write  input  1  1=write, 0=read.
REQ-009 SHALL have port req_addr  input  ADDR_W  word address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  read data available.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes read data.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data, oldest first.
REQ-014 SHALL have ports sram_a (output, ADDR_W), sram_i (output, DATA_W), sram_csb, sram_web and sram_oeb (outputs, 1, active-low), and sram_o (input, DATA_W), all connecting to the SRAM macro.
REQ-015 SHALL have port busy  output  1  high while the controller is in reset or zero-fill.

Function
REQ-016 SHALL define fire = req_valid & req_ready; the SRAM sees an access at the clock edge that ends a fire cycle.
REQ-017 SHALL drive SRAM pins combinationally in a fire cycle: sram_csb=0, sram_a=req_addr, sram_i=req_wdata, sram_web=~req_write, sram_oeb=req_write.
REQ-018 SHALL hold sram_csb=sram_web=sram_oeb=1 in every non-fire cycle; web and oeb never both low.
REQ-019 SHALL set a rd_pending flag for one cycle after a read fire and push sram_o into a 2-entry response FIFO in that cycle; read latency = 1 cycle from the accept edge to rsp_valid when the FIFO is empty.
REQ-020 SHALL issue no response for writes.
REQ-021 SHALL compute req_ready = ~busy & ((count + rd_pending - pop) < 2), where pop = rsp_valid & rsp_ready; req_ready SHALL NOT depend on req_write, req_addr or req_wdata.
REQ-022 SHALL present the FIFO head on rsp_rdata with rsp_valid = (count != 0); rsp_rdata is held stable while rsp_valid & ~rsp_ready.
REQ-023 SHALL handle a simultaneous push and pop at full or empty correctly; count never exceeds 2 and no response is dropped or duplicated.
REQ-024 SHALL return, for a read accepted one cycle after a write to the same address, the newly written data.

Reset
REQ-025 SHALL, while reset_n=0 at a clock edge, clear count, rd_pending and the FIFO pointers and set rsp_valid=0; req_ready=0, busy=1 and SRAM strobes are inactive during reset.
REQ-026 SHALL discard any in-flight read when reset is asserted mid-operation; no response for it appears after reset.

Configuration
REQ-027 SHALL, with SRAM1RW_CTRL_ZERO_FILL_EN defined, enter FILL after reset release, write 0 to addresses 0..DEPTH-1 at one per cycle (csb=0, web=0, oeb=1), hold busy=1 and req_ready=0 for exactly DEPTH cycles, then enter IDLE.
REQ-028 SHALL restart zero-fill at address 0 if reset is reasserted during FILL.
REQ-029 SHALL, without SRAM1RW_CTRL_ZERO_FILL_EN, deassert busy in the first cycle after reset release and omit the fill counter entirely.

Structure
REQ-030 SHALL place ADDR_W, DATA_W, DEPTH defaults and the addr_t/data_t typedefs in package sram1rw_ctrl_pkg.
REQ-031 SHALL implement the response queue as sub-module sram1rw_rsp_fifo (2 entries, DATA_W wide).

Verification
REQ-032 SHALL cover: write 0x1ABCD@0x005, then read @0x005 on the next cycle -> rsp_valid one cycle after the accept edge, rsp_rdata=0x1ABCD.
REQ-033 SHALL cover: rsp_ready=0 with back-to-back reads @0x001/0x002/0x003 -> two accepted, third stalled (req_ready=0); raising rsp_ready drains them in order.
REQ-034 SHALL cover: continuous reads with rsp_ready=1 -> one accept per cycle, no bubbles, data in address order.
REQ-035 SHALL cover: reset_n=0 pulsed with a read pending -> rsp_valid=0 after reset, no stale response.
REQ-036 SHALL cover (ZERO_FILL_EN): busy high for exactly 1024 cycles after reset release, then a read @0x3FF -> 0x00000.
REQ-037 SHALL cover: random read/write mix against a scoreboard -> web/oeb never both low, csb high outside fire cycles.
